// File: rtl/rffe_gpio_sequencer_pkg.sv
// Shared definitions for the RFFE GPIO sequencer.
// Op codes, PIO register offsets, response codes and FSM states.
package rffe_gpio_pkg;

   typedef enum logic [2:0] {
      OP_WRITE = 3'd0,
      OP_READ  = 3'd1,
      OP_SET   = 3'd2,
      OP_CLEAR = 3'd3,
      OP_POLL  = 3'd4
   } op_e;

   localparam int REG_DATA     = 0;
   localparam int REG_IRQ_MASK = 2;
   localparam int REG_SET      = 4;
   localparam int REG_CLEAR    = 5;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_TIMEOUT = 2'd1,
      ERR_ILLEGAL = 2'd2
   } err_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_ADDR,
      S_RD_WAIT,
      S_GAP,
      S_RSP
   } state_e;

endpackage

// File: rtl/rffe_gpio_sequencer.sv
// Avalon-MM initiator issuing single GPIO PIO commands
// (write/read/set/clear/poll) on behalf of RF control logic.
module rffe_gpio_sequencer
   import rffe_gpio_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 3,
   parameter int POLL_MAX = 1024,
   parameter int POLL_GAP = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [DATA_W-1:0] cmd_mask,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_err,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_chipselect,
   output logic              m_write_n,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata
);

   localparam logic [15:0] PMAX = 16'(POLL_MAX);
   localparam logic [7:0] GAP_LAST =
      (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

   state_e state_q, state_d;

   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] mask_q;
   logic [15:0]       poll_q;
   logic [7:0]        gap_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [1:0]        rsp_err_q;

   logic              accept;
   logic              legal;
   logic              is_rd;
   logic              hit;
   logic              done;
   logic [ADDR_W-1:0] wr_addr;

   assign accept = cmd_valid && (state_q == S_IDLE);
   assign legal  = (cmd_op <= OP_POLL);
   assign is_rd  = (cmd_op == OP_READ) || (cmd_op == OP_POLL);
   assign hit    = ((m_readdata ^ data_q) & mask_q) == '0;
   assign done   = (op_q != OP_POLL) || hit || (poll_q == PMAX);

   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RSP);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!legal)
                  state_d = S_RSP;
               else if (is_rd)
                  state_d = S_RD_ADDR;
               else
                  state_d = S_WR;
            end
         end
         S_WR:      state_d = S_RSP;
         S_RD_ADDR: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (done)
               state_d = S_RSP;
            else if (POLL_GAP > 0)
               state_d = S_GAP;
            else
               state_d = S_RD_ADDR;
         end
         S_GAP: begin
            if (gap_q == GAP_LAST)
               state_d = S_RD_ADDR;
         end
         S_RSP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // SET/CLEAR always target the PIO's bit-set/bit-clear registers
   always_comb begin
      wr_addr = addr_q;
      unique case (1'b1)
         op_q == OP_SET:   wr_addr = ADDR_W'(REG_SET);
         op_q == OP_CLEAR: wr_addr = ADDR_W'(REG_CLEAR);
         default:          wr_addr = addr_q;
      endcase
   end

   always_comb begin
      m_chipselect = 1'b0;
      m_write_n    = 1'b1;
      m_address    = '0;
      m_writedata  = '0;
      unique case (state_q)
         S_WR: begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_address    = wr_addr;
            m_writedata  = data_q;
         end
         S_RD_ADDR, S_RD_WAIT: begin
            m_chipselect = 1'b1;
            m_address    = addr_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         poll_q     <= '0;
         gap_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= ERR_OK;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q   <= cmd_op;
                  addr_q <= cmd_addr;
                  data_q <= cmd_data;
                  mask_q <= cmd_mask;
                  poll_q <= 16'd1;
                  gap_q  <= '0;
                  if (!legal) begin
                     rsp_data_q <= '0;
                     rsp_err_q  <= ERR_ILLEGAL;
                  end
               end
            end
            S_WR: begin
               rsp_data_q <= '0;
               rsp_err_q  <= ERR_OK;
            end
            S_RD_WAIT: begin
               if (done) begin
                  rsp_data_q <= m_readdata;
                  rsp_err_q  <= (op_q == OP_POLL && !hit)
                                ? ERR_TIMEOUT : ERR_OK;
               end else begin
                  poll_q <= poll_q + 16'd1;
                  gap_q  <= '0;
               end
            end
            S_GAP:   gap_q <= gap_q + 8'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rffe_gpio_sequencer.sv
// Bench for rffe_gpio_sequencer: PIO slave model plus a
// command-level reference predicting latency, bus traffic and response.
module tb_rffe_gpio_sequencer;

   localparam int DW   = 32;
   localparam int AW   = 3;
   localparam int PMAX = 5;
   localparam int PGAP = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic [DW-1:0] cmd_mask;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_err;
   logic [AW-1:0] m_address;
   logic          m_chipselect;
   logic          m_write_n;
   logic [DW-1:0] m_writedata;
   logic [DW-1:0] m_readdata = '0;

   always #5 clk = ~clk;

   rffe_gpio_sequencer #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .POLL_MAX(PMAX),
      .POLL_GAP(PGAP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .cmd_mask    (cmd_mask),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .m_address   (m_address),
      .m_chipselect(m_chipselect),
      .m_write_n   (m_write_n),
      .m_writedata (m_writedata),
      .m_readdata  (m_readdata)
   );

   // PIO slave: in_port value seen by read k of a command is sched[k]
   logic [DW-1:0] sched [1:8];
   logic [DW-1:0] out_port = '0;
   logic [DW-1:0] irq_reg  = '0;
   int            rd_edges = 0;
   int            rd_base  = 0;
   int            wr_cnt   = 0;
   int            bad_bus  = 0;
   logic [AW-1:0] wr_addr  = '0;
   logic [DW-1:0] wr_data  = '0;

   always @(posedge clk) begin
      int k;
      k = (rd_edges - rd_base) / 2 + 1;
      if (k > 8) k = 8;
      if (k < 1) k = 1;
      case (m_address)
         3'd0:    m_readdata <= sched[k];
         3'd2:    m_readdata <= irq_reg;
         default: m_readdata <= '0;
      endcase
      if (m_chipselect && m_write_n) rd_edges++;
      if (!m_write_n && !m_chipselect) bad_bus++;
      if (m_chipselect && !m_write_n) begin
         wr_cnt++;
         wr_addr = m_address;
         wr_data = m_writedata;
         case (m_address)
            3'd0:    out_port <= m_writedata;
            3'd2:    irq_reg  <= m_writedata;
            3'd4:    out_port <= out_port | m_writedata;
            3'd5:    out_port <= out_port & ~m_writedata;
            default: ;
         endcase
      end
   end

   int tests = 0;
   int fails = 0;
   logic [DW-1:0] m_out = '0;
   logic [DW-1:0] m_irq = '0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd_val(input logic [2:0] a,
                                            input int k);
      int j;
      j = (k > 8) ? 8 : k;
      if (a == 3'd0) return sched[j];
      if (a == 3'd2) return m_irq;
      return '0;
   endfunction

   task automatic run_cmd(input string tag, input logic [2:0] op,
                          input logic [2:0] addr, input logic [31:0] data,
                          input logic [31:0] mask);
      int lat, exp_lat, exp_rd, exp_wr, n, r0, w0;
      logic [31:0] exp_d;
      logic [2:0]  exp_wa;
      logic [1:0]  exp_e;
      exp_rd = 0;
      exp_wr = 0;
      exp_d  = '0;
      exp_e  = 2'd0;
      exp_wa = '0;
      exp_lat = 0;
      if (op > 3'd4) begin
         exp_lat = 1;
         exp_e   = 2'd2;
      end else if (op == 3'd1) begin
         exp_lat = 3;
         exp_rd  = 1;
         exp_d   = rd_val(addr, 1);
      end else if (op == 3'd4) begin
         n = 0;
         for (int k = 1; k <= PMAX; k++)
            if (n == 0 && ((rd_val(addr, k) ^ data) & mask) == '0)
               n = k;
         exp_rd  = (n == 0) ? PMAX : n;
         exp_e   = (n == 0) ? 2'd1 : 2'd0;
         exp_d   = rd_val(addr, exp_rd);
         exp_lat = 3 + (exp_rd - 1) * (2 + PGAP);
      end else begin
         exp_lat = 2;
         exp_wr  = 1;
         exp_wa  = (op == 3'd0) ? addr : (op == 3'd2) ? 3'd4 : 3'd5;
         case (exp_wa)
            3'd0:    m_out = data;
            3'd2:    m_irq = data;
            3'd4:    m_out = m_out | data;
            3'd5:    m_out = m_out & ~data;
            default: ;
         endcase
      end
      @(negedge clk);
      check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
      rd_base   = rd_edges;
      r0        = rd_edges;
      w0        = wr_cnt;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_mask  = mask;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_addr  = 3'($urandom);
      cmd_data  = $urandom;
      cmd_mask  = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".rsp_data"}, rsp_data, exp_d);
      check({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_e));
      check({tag, ".read_edges"}, 32'(rd_edges - r0), 32'(2 * exp_rd));
      check({tag, ".writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
      if (exp_wr == 1) begin
         check({tag, ".wr_addr"}, 32'(wr_addr), 32'(exp_wa));
         check({tag, ".wr_data"}, wr_data, data);
      end
      check({tag, ".out_port"}, out_port, m_out);
      @(posedge clk);
      #1;
      check({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, ".ready_after"}, 32'(cmd_ready), 32'd1);
      check({tag, ".rsp_hold"}, rsp_data, exp_d);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int quiet;
      logic [2:0] op;
      for (int k = 1; k <= 8; k++) sched[k] = '0;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_addr  = '0;
      cmd_data  = '0;
      cmd_mask  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.rsp_data", rsp_data, 32'd0);
      check("rst.rsp_err", 32'(rsp_err), 32'd0);
      check("rst.cs", 32'(m_chipselect), 32'd0);
      check("rst.write_n", 32'(m_write_n), 32'd1);
      check("rst.addr", 32'(m_address), 32'd0);
      check("rst.wdata", m_writedata, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_cmd("write", 3'd0, 3'd0, 32'h0001_8000, 32'h0);
      run_cmd("set", 3'd2, 3'd7, 32'h0000_0010, 32'h0);
      check("set.out", out_port, 32'h0001_8010);
      run_cmd("clear", 3'd3, 3'd1, 32'h0000_8000, 32'h0);
      check("clear.out", out_port, 32'h0001_0010);

      for (int k = 1; k <= 8; k++) sched[k] = 32'hDEAD_BEEF;
      run_cmd("read", 3'd1, 3'd0, 32'h0, 32'h0);

      for (int k = 1; k <= 8; k++) sched[k] = (k >= 4) ? 32'h4 : 32'h0;
      run_cmd("poll_gap", 3'd4, 3'd0, 32'h4, 32'h4);

      for (int k = 1; k <= 8; k++) sched[k] = 32'(k) << 8;
      run_cmd("poll_tmo", 3'd4, 3'd0, 32'h4, 32'h4);
      check("poll_tmo.last", rsp_data, 32'h0000_0500);

      run_cmd("poll_mask0", 3'd4, 3'd0, 32'hFFFF_FFFF, 32'h0);
      run_cmd("illegal", 3'd6, 3'd0, 32'h1234_5678, 32'h0);

      // Abort a READ while it waits for read data
      for (int k = 1; k <= 8; k++) sched[k] = 32'hCAFE_0001;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd1;
      cmd_addr  = 3'd0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort.cs_before", 32'(m_chipselect), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort.cs", 32'(m_chipselect), 32'd0);
      check("abort.ready", 32'(cmd_ready), 32'd1);
      check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
      reset = 1'b0;
      quiet = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (rsp_valid || m_chipselect) quiet++;
      end
      check("abort.quiet", 32'(quiet), 32'd0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] d, msk;
         for (int k = 1; k <= 8; k++) sched[k] = $urandom;
         if ($urandom_range(0, 9) >= 8)
            op = 3'($urandom_range(5, 7));
         else
            op = 3'($urandom_range(0, 4));
         d   = $urandom;
         msk = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
         if (op == 3'd4 && $urandom_range(0, 1) == 1)
            d = sched[$urandom_range(1, 7)];
         run_cmd($sformatf("rand%0d", i), op, 3'($urandom_range(0, 7)),
                 d, msk);
      end

      check("bus.write_n_without_cs", 32'(bad_bus), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
